// File: rtl/ptw_if.sv
// Requester, response and PTE-memory signals of the page-table walker.
// The slave modport is the walker; the master modport is the requester/memory side.
interface ptw_if #(
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]       req_valid;
    logic [NPORTS-1:0][63:0] req_addr;
    logic [NPORTS-1:0]       resp_valid;
    logic [63:0]             resp_paddr;
    logic [7:0]              resp_perm;
    logic [1:0]              resp_level;
    logic                    resp_fault;
    logic                    mem_req_valid;
    logic [63:0]             mem_req_addr;
    logic                    mem_resp_valid;
    logic [63:0]             mem_resp_data;
    logic [63:0]             root_pt_addr;

    modport slave (
        input  req_valid, req_addr, mem_resp_valid, mem_resp_data, root_pt_addr,
        output resp_valid, resp_paddr, resp_perm, resp_level, resp_fault,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, mem_resp_valid, mem_resp_data, root_pt_addr,
        input  resp_valid, resp_paddr, resp_perm, resp_level, resp_fault,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ptw_multiport.sv
// Sv39/Sv48 page-table walker shared by NPORTS requesters through one PTE read port,
// with round-robin grant, superpage support and fault reporting.
module ptw_multiport #(
    parameter int NPORTS = 2,
    parameter int LEVELS = 4
) (
    input logic  clk,
    input logic  reset,
    ptw_if.slave bus
);
    localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int VAW = 9 * LEVELS + 12;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   port_q, last_grant_q, grant_idx;
    logic [63:0]     va_q, pt_q, pte_q, grant_va;
    logic [1:0]      level_q;
    logic            fault_q;
    logic            grant_found, grant_canon;
    logic            walk_fault, walk_ptr;
    logic [64-VAW:0] va_top;
    logic [8:0]      fetch_vpn, sel0, sel1, sel2;
    logic            unused_bits;

    // A leaf above level 0 must have every PPN field below its level cleared.
    function automatic logic superpage_misaligned(input logic [63:0] pte, input logic [1:0] lvl);
        return ((lvl >= 2'd1) && (|pte[18:10])) ||
               ((lvl >= 2'd2) && (|pte[27:19])) ||
               ((lvl == 2'd3) && (|pte[36:28]));
    endfunction

    // Round-robin: try last_grant+1, last_grant+2, ... with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_va    = '0;
        for (int off = 1; off <= NPORTS; off++) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (!grant_found && bus.req_valid[j] &&
                    (j == (int'(last_grant_q) + off) % NPORTS)) begin
                    grant_found = 1'b1;
                    grant_idx   = PW'(j);
                    grant_va    = bus.req_addr[j];
                end
            end
        end
    end

    assign va_top      = grant_va[63:VAW-1];
    assign grant_canon = (&va_top) | ~(|va_top);

    always_comb begin
        walk_ptr   = ~|bus.mem_resp_data[3:1];
        walk_fault = ~bus.mem_resp_data[0] | (bus.mem_resp_data[2] & ~bus.mem_resp_data[1]);
        if (walk_ptr && (level_q == 2'd0)) walk_fault = 1'b1;
        if (!walk_ptr && superpage_misaligned(bus.mem_resp_data, level_q)) walk_fault = 1'b1;
    end

    always_comb begin
        case (level_q)
            2'd0:    fetch_vpn = va_q[20:12];
            2'd1:    fetch_vpn = va_q[29:21];
            2'd2:    fetch_vpn = va_q[38:30];
            default: fetch_vpn = va_q[47:39];
        endcase
    end

    // Superpage leaves pass the VA's lower VPN fields straight into the PPN.
    assign sel0 = (level_q == 2'd0)  ? pte_q[18:10] : va_q[20:12];
    assign sel1 = (level_q <= 2'd1)  ? pte_q[27:19] : va_q[29:21];
    assign sel2 = (level_q <= 2'd2)  ? pte_q[36:28] : va_q[38:30];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_addr   = '0;
        bus.resp_valid     = '0;
        bus.resp_paddr     = '0;
        bus.resp_perm      = '0;
        bus.resp_level     = '0;
        bus.resp_fault     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) state_d = grant_canon ? FETCH : RESP;
            end
            FETCH: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {pt_q[63:12], fetch_vpn, 3'b000};
                if (bus.mem_resp_valid && (walk_fault || !walk_ptr)) state_d = RESP;
            end
            RESP: begin
                for (int j = 0; j < NPORTS; j++) bus.resp_valid[j] = (port_q == PW'(j));
                bus.resp_fault = fault_q;
                bus.resp_level = level_q;
                if (!fault_q) begin
                    bus.resp_paddr = {8'b0, pte_q[53:37], sel2, sel1, sel0, va_q[11:0]};
                    bus.resp_perm  = pte_q[7:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_q       <= '0;
            last_grant_q <= PW'(NPORTS - 1);
            va_q         <= '0;
            pt_q         <= '0;
            pte_q        <= '0;
            level_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        port_q  <= grant_idx;
                        va_q    <= grant_va;
                        pt_q    <= {bus.root_pt_addr[63:12], 12'b0};
                        level_q <= 2'(LEVELS - 1);
                        fault_q <= ~grant_canon;
                        pte_q   <= '0;
                    end
                end
                FETCH: begin
                    if (bus.mem_resp_valid) begin
                        if (walk_fault) begin
                            fault_q <= 1'b1;
                        end else if (walk_ptr) begin
                            pt_q    <= {8'b0, bus.mem_resp_data[53:10], 12'b0};
                            level_q <= level_q - 2'd1;
                        end else begin
                            pte_q <= bus.mem_resp_data;
                        end
                    end
                end
                RESP:    last_grant_q <= port_q;
                default: ;
            endcase
        end
    end

    assign unused_bits = ^{pte_q[63:54], pte_q[9:8], va_q[63:48], pt_q[11:0],
                           bus.root_pt_addr[11:0]};
endmodule

// File: tb/tb_ptw_multiport.sv
// Directed bench for ptw_multiport: Sv48 (two ports) and Sv39 (one port) instances
// served by a table-driven PTE memory with programmable wait states.
module tb_ptw_multiport;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ptw_if #(.NPORTS(2)) bus_a ();
    ptw_if #(.NPORTS(1)) bus_b ();

    ptw_multiport #(.NPORTS(2), .LEVELS(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    ptw_multiport #(.NPORTS(1), .LEVELS(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        logic [1:0]  pv;
        logic [63:0] paddr;
        logic [7:0]  perm;
        logic [1:0]  level;
        logic        fault;
        int          cyc;
    } rsp_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] tab_addr [8];
    logic [63:0] tab_data [8];
    int          tab_n = 0;

    int          delay_a = 0;
    int          wait_a = 0;
    bit          busy_a = 0;
    bit          stale = 0;
    bit          unstable = 0;
    bit          onehot_bad = 0;
    logic [63:0] prev_addr_a = '0;
    logic [63:0] req_log [$];
    rsp_t        rq [$];
    int          req_cnt_b = 0;
    int          got_b = 0;
    logic [63:0] paddr_b = '0;
    logic [7:0]  perm_b = '0;

    rsp_t        last_r;
    int          last_lat;
    int          last_nreq;

    function automatic logic [63:0] lookup(input logic [63:0] a);
        for (int i = 0; i < tab_n; i++) if (tab_addr[i] == a) return tab_data[i];
        return 64'h0;
    endfunction

    // PTE memory for the Sv48 walker; a request is answered after delay_a extra cycles.
    always @(negedge clk) begin
        if (!bus_a.mem_req_valid) begin
            busy_a               = 0;
            bus_a.mem_resp_valid = stale;
            bus_a.mem_resp_data  = stale ? 64'h801 : 64'h0;
        end else begin
            if (!busy_a || bus_a.mem_resp_valid) begin
                wait_a = delay_a;
            end else begin
                wait_a = wait_a - 1;
                if (bus_a.mem_req_addr !== prev_addr_a) unstable = 1;
            end
            busy_a               = 1;
            prev_addr_a          = bus_a.mem_req_addr;
            bus_a.mem_resp_valid = (wait_a == 0);
            bus_a.mem_resp_data  = lookup(bus_a.mem_req_addr);
            if (wait_a == 0) req_log.push_back(bus_a.mem_req_addr);
        end
    end

    always @(negedge clk) begin
        bus_b.mem_resp_valid = bus_b.mem_req_valid;
        bus_b.mem_resp_data  = bus_b.mem_req_valid ? lookup(bus_b.mem_req_addr) : 64'h0;
        if (bus_b.mem_req_valid) req_cnt_b++;
    end

    always @(negedge clk) begin
        rsp_t r;
        cyc = cyc + 1;
        if (bus_a.resp_valid != 2'b00) begin
            if ($countones(bus_a.resp_valid) != 1) onehot_bad = 1;
            r.pv    = bus_a.resp_valid;
            r.paddr = bus_a.resp_paddr;
            r.perm  = bus_a.resp_perm;
            r.level = bus_a.resp_level;
            r.fault = bus_a.resp_fault;
            r.cyc   = cyc;
            rq.push_back(r);
        end
        if (bus_b.resp_valid[0]) begin
            got_b++;
            paddr_b = bus_b.resp_paddr;
            perm_b  = bus_b.resp_perm;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic mem_clear();
        tab_n = 0;
    endtask

    task automatic mem_set(input logic [63:0] a, input logic [63:0] d);
        tab_addr[tab_n] = a;
        tab_data[tab_n] = d;
        tab_n++;
    endtask

    task automatic mem_base();
        mem_clear();
        mem_set(64'h1000, 64'h801);
        mem_set(64'h2000, 64'hC01);
        mem_set(64'h3000, 64'h1001);
        mem_set(64'h4028, 64'h200000CF);
    endtask

    // One request on port p of the Sv48 walker; latency counted from the request cycle.
    task automatic walk_a(input string tag, input int p, input logic [63:0] va);
        int t0;
        req_log.delete();
        rq.delete();
        bus_a.req_addr[p]  = va;
        bus_a.req_valid[p] = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 300 && rq.size() == 0; i++) tick();
        bus_a.req_valid[p] = 1'b0;
        check({tag, ".done"}, 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
            last_r   = rq[0];
            last_lat = rq[0].cyc - t0;
        end else begin
            last_r   = '{pv: 2'b00, paddr: '0, perm: '0, level: '0, fault: 1'b0, cyc: 0};
            last_lat = -1;
        end
        last_nreq = req_log.size();
    endtask

    initial begin
        bus_a.req_valid    = '0;
        bus_a.req_addr     = '0;
        bus_a.root_pt_addr = 64'h1FFF;
        bus_b.req_valid    = '0;
        bus_b.req_addr     = '0;
        bus_b.root_pt_addr = 64'h1000;
        do_reset();

        check("rst.mem_req_valid", 64'(bus_a.mem_req_valid), 64'd0);
        check("rst.mem_req_addr", bus_a.mem_req_addr, 64'd0);
        check("rst.resp_valid", 64'(bus_a.resp_valid), 64'd0);
        check("rst.resp_paddr", bus_a.resp_paddr, 64'd0);

        // Sv48 4 KiB leaf; root low bits set and must be ignored
        mem_base();
        walk_a("sv48", 0, 64'h5123);
        check("sv48.nreq", 64'(last_nreq), 64'd4);
        check("sv48.req0", req_log[0], 64'h1000);
        check("sv48.req1", req_log[1], 64'h2000);
        check("sv48.req2", req_log[2], 64'h3000);
        check("sv48.req3", req_log[3], 64'h4028);
        check("sv48.port", 64'(last_r.pv), 64'b01);
        check("sv48.paddr", last_r.paddr, 64'h80000123);
        check("sv48.perm", 64'(last_r.perm), 64'hCF);
        check("sv48.level", 64'(last_r.level), 64'd0);
        check("sv48.fault", 64'(last_r.fault), 64'd0);
        check("sv48.latency", 64'(last_lat), 64'd5);

        // 2 MiB superpage and its misaligned variant
        mem_clear();
        mem_set(64'h1000, 64'h801);
        mem_set(64'h2000, 64'hC01);
        mem_set(64'h3008, 64'h200800CF);
        walk_a("mega", 0, 64'h234567);
        check("mega.nreq", 64'(last_nreq), 64'd3);
        check("mega.req2", req_log[2], 64'h3008);
        check("mega.paddr", last_r.paddr, 64'h80234567);
        check("mega.level", 64'(last_r.level), 64'd1);
        check("mega.fault", 64'(last_r.fault), 64'd0);
        check("mega.latency", 64'(last_lat), 64'd4);
        tab_data[2] = 64'h200804CF;
        walk_a("misal", 0, 64'h234567);
        check("misal.fault", 64'(last_r.fault), 64'd1);
        check("misal.paddr", last_r.paddr, 64'd0);
        check("misal.perm", 64'(last_r.perm), 64'd0);

        // Invalid level-2 PTE
        mem_clear();
        mem_set(64'h1000, 64'h801);
        mem_set(64'h2000, 64'h800);
        walk_a("inval", 0, 64'h5123);
        check("inval.nreq", 64'(last_nreq), 64'd2);
        check("inval.fault", 64'(last_r.fault), 64'd1);
        check("inval.paddr", last_r.paddr, 64'd0);

        // Write-only leaf
        mem_base();
        tab_data[3] = 64'h5;
        walk_a("wnor", 0, 64'h5123);
        check("wnor.nreq", 64'(last_nreq), 64'd4);
        check("wnor.fault", 64'(last_r.fault), 64'd1);
        check("wnor.perm", 64'(last_r.perm), 64'd0);

        // Non-canonical VA: no memory traffic, response in the cycle after acceptance
        walk_a("noncanon", 0, 64'h0001000000000000);
        check("noncanon.nreq", 64'(last_nreq), 64'd0);
        check("noncanon.fault", 64'(last_r.fault), 64'd1);
        check("noncanon.paddr", last_r.paddr, 64'd0);
        check("noncanon.latency", 64'(last_lat), 64'd1);

        // Both ports requesting continuously from reset
        mem_base();
        mem_set(64'h3008, 64'h200800CF);
        do_reset();
        rq.delete();
        bus_a.req_addr[0]  = 64'h5123;
        bus_a.req_addr[1]  = 64'h234567;
        bus_a.req_valid    = 2'b11;
        for (int i = 0; i < 300 && rq.size() < 4; i++) tick();
        bus_a.req_valid    = 2'b00;
        check("arb.count", 64'(rq.size()), 64'd4);
        check("arb.g0", 64'(rq[0].pv), 64'b01);
        check("arb.g1", 64'(rq[1].pv), 64'b10);
        check("arb.g2", 64'(rq[2].pv), 64'b01);
        check("arb.g3", 64'(rq[3].pv), 64'b10);
        check("arb.pa0", rq[0].paddr, 64'h80000123);
        check("arb.pa1", rq[1].paddr, 64'h80234567);
        check("arb.gap01", 64'(rq[1].cyc - rq[0].cyc), 64'd5);
        check("arb.gap12", 64'(rq[2].cyc - rq[1].cyc), 64'd6);
        check("arb.onehot", 64'(onehot_bad), 64'd0);
        tick();

        // Five wait states per PTE read
        delay_a  = 5;
        unstable = 0;
        walk_a("wait", 0, 64'h5123);
        check("wait.paddr", last_r.paddr, 64'h80000123);
        check("wait.stable", 64'(unstable), 64'd0);
        check("wait.latency", 64'(last_lat), 64'd25);

        // Reset in FETCH, then a stale PTE response
        rq.delete();
        bus_a.req_addr[0]  = 64'h5123;
        bus_a.req_valid[0] = 1'b1;
        repeat (3) tick();
        check("mid.fetching", 64'(bus_a.mem_req_valid), 64'd1);
        bus_a.req_valid[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.req_after_rst", 64'(bus_a.mem_req_valid), 64'd0);
        check("mid.resp_after_rst", 64'(bus_a.resp_valid), 64'd0);
        stale = 1;
        tick();
        stale = 0;
        tick();
        check("mid.stale_req", 64'(bus_a.mem_req_valid), 64'd0);
        check("mid.stale_resp", 64'(rq.size()), 64'd0);
        delay_a = 0;
        walk_a("restart", 0, 64'h5123);
        check("restart.req0", req_log[0], 64'h1000);
        check("restart.nreq", 64'(last_nreq), 64'd4);
        check("restart.paddr", last_r.paddr, 64'h80000123);

        // Sv39 instance
        mem_clear();
        mem_set(64'h1000, 64'h801);
        mem_set(64'h2000, 64'hC01);
        mem_set(64'h3028, 64'h200000CF);
        req_cnt_b = 0;
        got_b     = 0;
        bus_b.req_addr[0]  = 64'h5123;
        bus_b.req_valid[0] = 1'b1;
        for (int i = 0; i < 100 && got_b == 0; i++) tick();
        bus_b.req_valid[0] = 1'b0;
        check("sv39.done", 64'(got_b), 64'd1);
        check("sv39.nreq", 64'(req_cnt_b), 64'd3);
        check("sv39.paddr", paddr_b, 64'h80000123);
        check("sv39.perm", 64'(perm_b), 64'hCF);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
